// File: rtl/chip8_fb_pkg.sv
// Shared types and default geometry for the framebuffer arbiter slice.
package chip8_fb_pkg;

    localparam int unsigned DEF_ADDR_W      = 9;
    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_CLEAR_WORDS = 512;

    typedef enum logic [1:0] {
        OwnNone,
        OwnDisp,
        OwnClr,
        OwnCpu
    } owner_e;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StAck
    } cpu_state_e;

endpackage

// File: rtl/fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter (slave) and its users plus RAM (master).
interface fb_arbiter_if #(
    parameter int unsigned ADDR_W = chip8_fb_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = chip8_fb_pkg::DEF_DATA_W
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              clr_start;
    logic              clr_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, clr_start, ram_rdata,
        output disp_data, cpu_ack, cpu_rdata, clr_busy, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, clr_start, ram_rdata,
        input  disp_data, cpu_ack, cpu_rdata, clr_busy, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/fb_clear_engine.sv
// Clear sweep pointer: writes zero to 0..CLEAR_WORDS-1, one word per granted cycle.
module fb_clear_engine
    import chip8_fb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned CLEAR_WORDS = DEF_CLEAR_WORDS
) (
    input  logic              clk,
    input  logic              res,
    input  logic              i_start,
    input  logic              i_gnt,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_ptr
);
    localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(CLEAR_WORDS - 1);

    logic              r_busy;
    logic [ADDR_W-1:0] r_ptr;

    // A start pulse always wins, so a restart during a granted write rewinds to 0.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_busy <= 1'b0;
            r_ptr  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_ptr  <= '0;
        end else if (i_gnt) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            if (r_ptr == LastPtr) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_ptr  = r_ptr;

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: display > clear > CPU, with a one-word display cache.
// Build option FB_CLEAR_EN enables the hardware clear engine.
module fb_arbiter
    import chip8_fb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned CLEAR_WORDS = DEF_CLEAR_WORDS
) (
    input  logic         clk,
    input  logic         res,
    fb_arbiter_if.slave  bus
);
    owner_e            r_owner, w_owner_d;
    cpu_state_e        r_state, w_state_d;
    logic              r_cache_vld;
    logic [ADDR_W-1:0] r_cache_addr;
    logic [DATA_W-1:0] r_disp_data;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              w_clr_busy;
    logic              w_clr_start;
    logic [ADDR_W-1:0] w_clr_ptr;
    logic              w_disp_need;
    logic              w_gnt_disp;
    logic              w_gnt_clr;
    logic              w_gnt_cpu;
    logic              w_wr_hit;

    assign w_disp_need = bus.disp_req && !(r_cache_vld && (bus.disp_addr == r_cache_addr));

    // Grants are gated by res so the RAM port shows idle values while reset is held.
    assign w_gnt_disp = res && w_disp_need;
    assign w_gnt_clr  = res && !w_disp_need && w_clr_busy;
    assign w_gnt_cpu  = res && !w_disp_need && !w_clr_busy && (r_state == StIdle) && bus.cpu_req;

`ifdef FB_CLEAR_EN
    fb_clear_engine #(
        .ADDR_W      (ADDR_W),
        .CLEAR_WORDS (CLEAR_WORDS)
    ) u_clear (
        .clk     (clk),
        .res     (res),
        .i_start (bus.clr_start),
        .i_gnt   (w_gnt_clr),
        .o_busy  (w_clr_busy),
        .o_ptr   (w_clr_ptr)
    );
    assign w_clr_start = bus.clr_start;
`else
    logic w_unused_clr;
    assign w_clr_busy   = 1'b0;
    assign w_clr_ptr    = '0;
    assign w_clr_start  = 1'b0;
    assign w_unused_clr = bus.clr_start & (CLEAR_WORDS != 0);
`endif

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        w_owner_d     = OwnNone;
        if (w_gnt_disp) begin
            bus.ram_addr = bus.disp_addr;
            w_owner_d    = OwnDisp;
        end else if (w_gnt_clr) begin
            bus.ram_we   = 1'b1;
            bus.ram_addr = w_clr_ptr;
            w_owner_d    = OwnClr;
        end else if (w_gnt_cpu) begin
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_we    = bus.cpu_we;
            bus.ram_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
            w_owner_d     = OwnCpu;
        end
    end

    assign w_wr_hit = bus.ram_we && (bus.ram_addr == r_cache_addr);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_gnt_cpu) w_state_d = bus.cpu_we ? StAck : StRd;
            StRd:    w_state_d = StAck;
            StAck:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state      <= StIdle;
            r_owner      <= OwnNone;
            r_cache_vld  <= 1'b0;
            r_cache_addr <= '0;
            r_disp_data  <= '0;
            r_cpu_rdata  <= '0;
        end else begin
            r_state <= w_state_d;
            r_owner <= w_owner_d;
            if (w_gnt_disp) begin
                r_cache_vld  <= 1'b1;
                r_cache_addr <= bus.disp_addr;
            end
            // Any write to the cached word, or a new sweep, forces the display to re-read.
            if (w_wr_hit || w_clr_start) begin
                r_cache_vld <= 1'b0;
            end
            if (r_owner == OwnDisp) begin
                r_disp_data <= bus.ram_rdata;
            end
            if ((r_state == StRd) && (r_owner == OwnCpu)) begin
                r_cpu_rdata <= bus.ram_rdata;
            end
        end
    end

    assign bus.disp_data = r_disp_data;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_ack   = (r_state == StAck);
    assign bus.clr_busy  = w_clr_busy;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a synchronous-read RAM model and write/read monitors.
module tb_fb_arbiter;
    import chip8_fb_pkg::*;

    localparam int unsigned AW = DEF_ADDR_W;
    localparam int unsigned DW = DEF_DATA_W;
    localparam int unsigned NW = DEF_CLEAR_WORDS;

    logic clk;
    logic res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .CLEAR_WORDS (NW)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    // RAM model with a backdoor preload port
    logic [DW-1:0] mem [NW];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t wr_log [$];
    int  rd_cnt [NW];
    int  ack_cnt;

    always @(negedge clk) begin
        if (res === 1'b1) begin
            if (bus.ram_we) wr_log.push_back({bus.ram_addr, bus.ram_wdata});
            else rd_cnt[bus.ram_addr]++;
            if (bus.cpu_ack) ack_cnt++;
        end
    end

    int checks;
    int failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    // Issues a CPU read in a cycle where nothing else competes.
    task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = a;
        #1;
        chk({tag, "_addr"}, 32'(bus.ram_addr), 32'(a));
        chk({tag, "_we"}, 32'(bus.ram_we), 32'd0);
        step();
        chk({tag, "_ack_n1"}, 32'(bus.cpu_ack), 32'd0);
        step();
        chk({tag, "_ack_n2"}, 32'(bus.cpu_ack), 32'd1);
        chk({tag, "_rdata"}, 32'(bus.cpu_rdata), 32'(exp));
        bus.cpu_req = 1'b0;
        step();
        chk({tag, "_ack_n3"}, 32'(bus.cpu_ack), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  n;
        int  errs;
        int  acks0;
        wr_t e;

        checks   = 0;
        failures = 0;
        ack_cnt  = 0;
        res      = 1'b0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.clr_start = 1'b0;

        preload(9'h010, 16'h1234);
        preload(9'h011, 16'hABCD);
        preload(9'h005, 16'h5555);
        preload(9'h1FF, 16'hBEEF);
        preload(9'h1FE, 16'hCAFE);
        preload(9'h020, 16'h7777);

        // Reset values with requests presented
        bus.disp_req  = 1'b1;
        bus.disp_addr = 9'h033;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 9'h044;
        bus.cpu_wdata = 16'hFFFF;
        #1;
        chk("rst_disp_data", 32'(bus.disp_data), 32'h0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'h0);
        chk("rst_clr_busy", 32'(bus.clr_busy), 32'h0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'h0);
        bus.disp_req = 1'b0;
        bus.cpu_req  = 1'b0;
        step();
        res = 1'b1;

        // Display only
        bus.disp_req  = 1'b1;
        bus.disp_addr = 9'h010;
        #1;
        chk("disp_gnt_addr", 32'(bus.ram_addr), 32'h010);
        step();
        chk("disp_hit_idle", 32'(bus.ram_addr), 32'h0);
        chk("disp_data_n1", 32'(bus.disp_data), 32'h0);
        step();
        chk("disp_data_n2", 32'(bus.disp_data), 32'h1234);
        bus.disp_addr = 9'h011;
        step();
        chk("disp_data_hold", 32'(bus.disp_data), 32'h1234);
        step();
        chk("disp_data_011", 32'(bus.disp_data), 32'hABCD);
        for (int i = 0; i < 4; i++) step();
        chk("disp_reads_010", 32'(rd_cnt[9'h010]), 32'd1);
        chk("disp_reads_011", 32'(rd_cnt[9'h011]), 32'd1);

        // CPU write to the cached display word
        bus.disp_addr = 9'h005;
        step();
        step();
        chk("wr_disp_pre", 32'(bus.disp_data), 32'h5555);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 9'h005;
        bus.cpu_wdata = 16'h0F0F;
        #1;
        chk("wr_gnt_we", 32'(bus.ram_we), 32'h1);
        chk("wr_gnt_addr", 32'(bus.ram_addr), 32'h005);
        chk("wr_gnt_wdata", 32'(bus.ram_wdata), 32'h0F0F);
        acks0 = ack_cnt;
        step();
        chk("wr_ack", 32'(bus.cpu_ack), 32'h1);
        chk("wr_reread_addr", 32'(bus.ram_addr), 32'h005);
        chk("wr_reread_we", 32'(bus.ram_we), 32'h0);
        bus.cpu_req = 1'b0;
        step();
        chk("wr_ack_off", 32'(bus.cpu_ack), 32'h0);
        step();
        chk("wr_disp_new", 32'(bus.disp_data), 32'h0F0F);
        chk("wr_ack_pulses", 32'(ack_cnt - acks0), 32'd1);

        // CPU reads with the display idle
        bus.disp_req = 1'b0;
        cpu_read(9'h005, 16'h0F0F, "rd_after_wr");
        cpu_read(9'h1FF, 16'hBEEF, "rd_1ff");

        // CPU read with a display read landing in the RD cycle
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 9'h1FE;
        #1;
        chk("rdc_addr", 32'(bus.ram_addr), 32'h1FE);
        step();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 9'h020;
        #1;
        chk("rdc_disp_addr", 32'(bus.ram_addr), 32'h020);
        step();
        chk("rdc_ack", 32'(bus.cpu_ack), 32'h1);
        chk("rdc_rdata", 32'(bus.cpu_rdata), 32'hCAFE);
        bus.cpu_req = 1'b0;
        step();
        chk("rdc_disp_data", 32'(bus.disp_data), 32'h7777);
        chk("rdc_rdata_hold", 32'(bus.cpu_rdata), 32'hCAFE);

        // Reset in the middle of a CPU read
        bus.disp_req = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 9'h1FF;
        step();
        res = 1'b0;
        #1;
        chk("rstm_ack", 32'(bus.cpu_ack), 32'h0);
        chk("rstm_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        chk("rstm_disp_data", 32'(bus.disp_data), 32'h0);
        chk("rstm_ram_addr", 32'(bus.ram_addr), 32'h0);
        chk("rstm_ram_we", 32'(bus.ram_we), 32'h0);
        step();
        step();
        chk("rstm_no_ack", 32'(bus.cpu_ack), 32'h0);
        bus.cpu_req = 1'b0;
        res = 1'b1;
        step();

`ifdef FB_CLEAR_EN
        // Full sweep with a CPU write queued behind it
        base = wr_log.size();
        bus.clr_start = 1'b1;
        #1;
        chk("clr_busy_pre", 32'(bus.clr_busy), 32'h0);
        step();
        bus.clr_start = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 9'h030;
        bus.cpu_wdata = 16'h4242;
        #1;
        chk("clr_first_we", 32'(bus.ram_we), 32'h1);
        chk("clr_first_addr", 32'(bus.ram_addr), 32'h0);
        chk("clr_first_wdata", 32'(bus.ram_wdata), 32'h0);
        acks0 = ack_cnt;
        n = 0;
        while (bus.clr_busy === 1'b1 && n < 2000) begin
            n++;
            step();
        end
        chk("clr_busy_cycles", 32'(n), 32'd512);
        chk("clr_cpu_waited", 32'(ack_cnt - acks0), 32'd0);
        chk("clr_cpu_we", 32'(bus.ram_we), 32'h1);
        chk("clr_cpu_addr", 32'(bus.ram_addr), 32'h030);
        chk("clr_cpu_wdata", 32'(bus.ram_wdata), 32'h4242);
        step();
        chk("clr_cpu_ack", 32'(bus.cpu_ack), 32'h1);
        bus.cpu_req = 1'b0;
        chk("clr_nwrites", 32'(wr_log.size() - base), 32'd513);
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            if (base + i < wr_log.size()) begin
                e = wr_log[base + i];
                if (e.a !== AW'(i) || e.d !== '0) errs++;
            end else begin
                errs++;
            end
        end
        chk("clr_order", 32'(errs), 32'd0);
        if (base + 512 < wr_log.size()) e = wr_log[base + 512];
        else e = '0;
        chk("clr_cpu_logged", 32'(e), 32'({9'h030, 16'h4242}));

        // Restart at pointer 100, then reset at pointer 50
        step();
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk("rst_ptr100", 32'(bus.ram_addr), 32'd100);
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        chk("restart_addr", 32'(bus.ram_addr), 32'd0);
        chk("restart_we", 32'(bus.ram_we), 32'h1);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 9'h031;
        bus.cpu_wdata = 16'h1111;
        for (int i = 0; i < 50; i++) step();
        chk("ptr50_addr", 32'(bus.ram_addr), 32'd50);
        acks0 = ack_cnt;
        res = 1'b0;
        #1;
        chk("rsw_busy", 32'(bus.clr_busy), 32'h0);
        chk("rsw_we", 32'(bus.ram_we), 32'h0);
        chk("rsw_addr", 32'(bus.ram_addr), 32'h0);
        chk("rsw_wdata", 32'(bus.ram_wdata), 32'h0);
        chk("rsw_ack", 32'(bus.cpu_ack), 32'h0);
        step();
        step();
        chk("rsw_no_ack", 32'(ack_cnt - acks0), 32'd0);
        bus.cpu_req = 1'b0;
        res = 1'b1;
        step();
        chk("rsw_aborted", 32'(bus.clr_busy), 32'h0);
        chk("rsw_idle_we", 32'(bus.ram_we), 32'h0);
`else
        // Clear engine absent: start pulse must do nothing
        base = wr_log.size();
        bus.clr_start = 1'b1;
        #1;
        chk("noclr_busy0", 32'(bus.clr_busy), 32'h0);
        chk("noclr_we0", 32'(bus.ram_we), 32'h0);
        step();
        bus.clr_start = 1'b0;
        chk("noclr_busy1", 32'(bus.clr_busy), 32'h0);
        chk("noclr_we1", 32'(bus.ram_we), 32'h0);
        step();
        step();
        chk("noclr_nwrites", 32'(wr_log.size() - base), 32'd0);
        chk("noclr_busy3", 32'(bus.clr_busy), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
